shift_rotate_seq: RTL and testbench
===================================

SHIFT_ROTATE_SEQ -- requirements
Module: shift_rotate_seq

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, WIDTH >= 2.
REQ-002 Parameter AMT_BITS, default 4: width of the shift/rotate amount field, so amounts 0..2^AMT_BITS-1 are legal, including amounts >= WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/command presented.
REQ-006 in_ready  output  1  block can accept a command.
REQ-007 a  input  WIDTH  operand.
REQ-008 amt  input  AMT_BITS  number of single-bit steps.
REQ-009 op  input  3  operation: 000 ROL, 001 ROR, 010 RCL (through carry), 011 RCR (through carry), 100 SHL, 101 SHR (logical), 110 SAR (arithmetic), 111 PASS.
REQ-010 cin  input  1  carry in.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 y  output  WIDTH  result.
REQ-014 cout  output  1  carry out.
REQ-015 zero  output  1  high when y == 0.

Function
REQ-016 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a command is accepted on an edge where in_valid && in_ready.
REQ-018 On acceptance, the block SHALL latch a, amt, op and cin into an internal data register D, counter CNT and carry register C; D <= a, C <= cin, CNT <= amt.
REQ-019 After acceptance, if amt == 0 or op == PASS, the FSM SHALL go to DONE; otherwise it goes to RUN.
REQ-020 In RUN, each cycle performs exactly one 1-bit step on {D,C} and decrements CNT; when CNT reaches 1, the step is taken and the FSM goes to DONE.
REQ-021 ROL step: D <= {D[W-2:0], D[W-1]}, C <= D[W-1]; ROR: D <= {D[0], D[W-1:1]}, C <= D[0].
REQ-022 RCL step: D <= {D[W-2:0], C}, C <= D[W-1]; RCR: D <= {C, D[W-1:1]}, C <= D[0] (a WIDTH+1-bit ring).
REQ-023 SHL step: D <= {D[W-2:0], 0}, C <= D[W-1]; SHR: D <= {0, D[W-1:1]}, C <= D[0]; SAR: D <= {D[W-1], D[W-1:1]}, C <= D[0].
REQ-024 Amounts >= WIDTH SHALL NOT be reduced modulo anything; all steps are executed, so SHL/SHR yield 0 and SAR yields sign-fill.
REQ-025 For amt == 0 or PASS, y SHALL equal a and cout SHALL equal cin.
REQ-026 Latency: out_valid SHALL assert 1 cycle after acceptance for amt == 0/PASS, otherwise amt+1 cycles after acceptance.
REQ-027 In DONE, out_valid = 1, y = D, cout = C, zero = (D == 0); these SHALL remain stable until out_valid && out_ready.
REQ-028 On out_valid && out_ready, the FSM SHALL return to IDLE; no new command is accepted in that same cycle.
REQ-029 Outside DONE, out_valid SHALL be 0; y, cout and zero SHALL hold their last values.
REQ-030 in_valid, a, amt, op and cin SHALL be ignored in RUN and DONE.

Reset
REQ-031 While rst is high at a rising edge, the block SHALL enter IDLE with D = 0, C = 0, CNT = 0; after that edge, in_ready = 1, out_valid = 0, y = 0, cout = 0, zero = 1.
REQ-032 A reset asserted in RUN or DONE SHALL abort the operation without producing out_valid; rst SHALL take priority over all handshakes.

Verification
REQ-033 ROL, a=0x81, amt=1, cin=0 -> out_valid 2 cycles after acceptance, y=0x03, cout=1, zero=0.
REQ-034 RCR, a=0x01, amt=1, cin=0 -> y=0x00, cout=1, zero=1; RCL, a=0x80, amt=9, cin=0 -> y=0x80, cout=0 (full ring).
REQ-035 SAR, a=0x80, amt=7 -> out_valid 8 cycles after acceptance, y=0xFF, cout=0; SHL, a=0xFF, amt=8 -> y=0x00, cout=1, zero=1.
REQ-036 PASS or amt=0, a=0x5A, cin=1 -> y=0x5A, cout=1, 1-cycle latency.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles in DONE -> y, cout, zero and out_valid stay stable, in_ready=0, and in_valid pulses are ignored; handshake -> IDLE next cycle.
REQ-038 Reset mid-RUN (SHR, a=0xF0, amt=6, rst asserted on the 3rd RUN cycle) -> no out_valid; IDLE outputs per REQ-031; the next command completes normally.

Source files
------------

// File: rtl/shift_rotate_seq.sv
// Sequential shifter/rotator: one 1-bit step per cycle on a {data, carry} pair,
// with a valid/ready command input and a valid/ready result output.
module shift_rotate_seq #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned AMT_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    a,
   input  logic [AMT_BITS-1:0] amt,
   input  logic [2:0]          op,
   input  logic                cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    y,
   output logic                cout,
   output logic                zero
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [2:0] OP_ROL  = 3'd0;
   localparam logic [2:0] OP_ROR  = 3'd1;
   localparam logic [2:0] OP_RCL  = 3'd2;
   localparam logic [2:0] OP_RCR  = 3'd3;
   localparam logic [2:0] OP_SHL  = 3'd4;
   localparam logic [2:0] OP_SHR  = 3'd5;
   localparam logic [2:0] OP_SAR  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    d_q, d_d;
   logic                c_q, c_d;
   logic [AMT_BITS-1:0] cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [WIDTH-1:0]    y_q, y_d;
   logic                cout_q, cout_d;
   logic                zero_q, zero_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    step_d;
   logic                step_c;

   // One 1-bit step of the latched operation on {D, C}.
   always_comb begin
      step_d = d_q;
      step_c = c_q;
      unique case (op_q)
         OP_ROL:  begin step_d = {d_q[WIDTH-2:0], d_q[WIDTH-1]};  step_c = d_q[WIDTH-1]; end
         OP_ROR:  begin step_d = {d_q[0], d_q[WIDTH-1:1]};        step_c = d_q[0];       end
         OP_RCL:  begin step_d = {d_q[WIDTH-2:0], c_q};           step_c = d_q[WIDTH-1]; end
         OP_RCR:  begin step_d = {c_q, d_q[WIDTH-1:1]};           step_c = d_q[0];       end
         OP_SHL:  begin step_d = {d_q[WIDTH-2:0], 1'b0};          step_c = d_q[WIDTH-1]; end
         OP_SHR:  begin step_d = {1'b0, d_q[WIDTH-1:1]};          step_c = d_q[0];       end
         OP_SAR:  begin step_d = {d_q[WIDTH-1], d_q[WIDTH-1:1]};  step_c = d_q[0];       end
         default: begin step_d = d_q;                             step_c = c_q;          end
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      y_d     = y_q;
      cout_d  = cout_q;
      zero_d  = zero_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               d_d     = a;
               c_d     = cin;
               cnt_d   = amt;
               op_d    = op;
               state_d = (amt == '0 || op == OP_PASS) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            d_d   = step_d;
            c_d   = step_c;
            cnt_d = cnt_q - AMT_BITS'(1);
            if (cnt_q == AMT_BITS'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Result registers track D/C only while DONE, so they hold elsewhere.
      if (state_d == S_DONE) begin
         y_d    = d_d;
         cout_d = c_d;
         zero_d = (d_d == '0);
      end
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         d_q         <= '0;
         c_q         <= 1'b0;
         cnt_q       <= '0;
         op_q        <= '0;
         y_q         <= '0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b1;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_q         <= d_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         y_q         <= y_d;
         cout_q      <= cout_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign cout      = cout_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Scoreboard bench for shift_rotate_seq: expected results queued at drive time,
// popped and compared when out_valid appears.
module tb_shift_rotate_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [3:0] amt;
   logic [2:0] op;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic       cout;
   logic       zero;

   always #5 clk = ~clk;

   shift_rotate_seq #(.WIDTH(8), .AMT_BITS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .amt(amt), .op(op), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .cout(cout), .zero(zero)
   );

   typedef struct {
      logic [7:0] y;
      logic       c;
      logic       z;
      int         lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {cout, y} after n single-bit steps of the given op.
   function automatic logic [8:0] model(input logic [7:0] av, input logic [3:0] n,
                                        input logic [2:0] o, input logic ci);
      logic [7:0] d;
      logic       c;
      d = av;
      c = ci;
      if (o != 3'd7) begin
         for (int i = 0; i < int'(n); i++) begin
            case (o)
               3'd0: {d, c} = {d[6:0], d[7], d[7]};
               3'd1: {d, c} = {d[0], d[7:1], d[0]};
               3'd2: {d, c} = {d[6:0], c, d[7]};
               3'd3: {d, c} = {c, d[7:1], d[0]};
               3'd4: {d, c} = {d[6:0], 1'b0, d[7]};
               3'd5: {d, c} = {1'b0, d[7:1], d[0]};
               default: {d, c} = {d[7], d[7:1], d[0]};
            endcase
         end
      end
      return {c, d};
   endfunction

   task automatic push_model(input logic [7:0] av, input logic [3:0] n,
                             input logic [2:0] o, input logic ci);
      exp_t       e;
      logic [8:0] r;
      r     = model(av, n, o, ci);
      e.y   = r[7:0];
      e.c   = r[8];
      e.z   = (r[7:0] == 8'h00);
      e.lat = (n == 4'd0 || o == 3'd7) ? 1 : int'(n) + 1;
      sb_q.push_back(e);
   endtask

   task automatic push_const(input logic [7:0] ey, input logic ec, input logic ez, input int el);
      exp_t e;
      e.y = ey; e.c = ec; e.z = ez; e.lat = el;
      sb_q.push_back(e);
   endtask

   // Issue a command whose expectation is already queued, then drain it with
   // `hold` cycles of backpressure during which in_valid is pulsed.
   task automatic run_cmd(input logic [7:0] av, input logic [3:0] n,
                          input logic [2:0] o, input logic ci, input int hold);
      exp_t e;
      int   lat;
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = av; amt = n; op = o; cin = ci;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      e = sb_q.pop_front();
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("latency", 32'(lat), 32'(e.lat));
      chk("y", 32'(y), 32'(e.y));
      chk("cout", 32'(cout), 32'(e.c));
      chk("zero", 32'(zero), 32'(e.z));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = 8'($urandom); amt = 4'($urandom); op = 3'($urandom);
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_y", 32'(y), 32'(e.y));
         chk("bp_cout", 32'(cout), 32'(e.c));
         chk("bp_zero", 32'(zero), 32'(e.z));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_hs_out_valid", 32'(out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(in_ready), 32'd1);
      chk("post_hs_y_hold", 32'(y), 32'(e.y));
   endtask

   initial begin
      logic [7:0] ra;
      logic [3:0] rn;
      logic [2:0] ro;
      logic       rc;
      rst = 1'b1; in_valid = 1'b0; a = '0; amt = '0; op = '0; cin = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      rst = 1'b0;

      // Directed vectors with hand-derived expectations.
      push_const(8'h03, 1'b1, 1'b0, 2);  run_cmd(8'h81, 4'd1,  3'd0, 1'b0, 0); // ROL
      push_const(8'h00, 1'b1, 1'b1, 2);  run_cmd(8'h01, 4'd1,  3'd3, 1'b0, 0); // RCR
      push_const(8'h80, 1'b0, 1'b0, 10); run_cmd(8'h80, 4'd9,  3'd2, 1'b0, 0); // RCL full ring
      push_const(8'hFF, 1'b0, 1'b0, 8);  run_cmd(8'h80, 4'd7,  3'd6, 1'b0, 0); // SAR
      push_const(8'h00, 1'b1, 1'b1, 9);  run_cmd(8'hFF, 4'd8,  3'd4, 1'b0, 0); // SHL by WIDTH
      push_const(8'h5A, 1'b1, 1'b0, 1);  run_cmd(8'h5A, 4'd5,  3'd7, 1'b1, 0); // PASS
      push_const(8'h5A, 1'b1, 1'b0, 1);  run_cmd(8'h5A, 4'd0,  3'd1, 1'b1, 3); // amt 0 + backpressure
      push_const(8'h00, 1'b0, 1'b1, 16); run_cmd(8'hFF, 4'd15, 3'd5, 1'b1, 0); // SHR past WIDTH
      push_const(8'hFF, 1'b1, 1'b0, 16); run_cmd(8'h80, 4'd15, 3'd6, 1'b0, 0); // SAR sign fill
      push_const(8'h0F, 1'b0, 1'b0, 5);  run_cmd(8'hF0, 4'd4,  3'd1, 1'b1, 1); // ROR nibble swap

      // Random commands against the reference model.
      for (int k = 0; k < 24; k++) begin
         ra = 8'($urandom); rn = 4'($urandom); ro = 3'($urandom); rc = 1'($urandom);
         push_model(ra, rn, ro, rc);
         run_cmd(ra, rn, ro, rc, int'($urandom_range(0, 2)));
      end

      // Reset on the 3rd RUN cycle of SHR 0xF0 by 6 aborts the operation.
      @(negedge clk);
      in_valid = 1'b1; a = 8'hF0; amt = 4'd6; op = 3'd5; cin = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("abort_run1_ov", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("abort_run2_ov", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_y", 32'(y), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_zero", 32'(zero), 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_no_ov", 32'(out_valid), 32'd0);
      end
      push_const(8'h3C, 1'b0, 1'b0, 3);  run_cmd(8'hF0, 4'd2, 3'd5, 1'b0, 0);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
